// File: rtl/tft_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tft_timing_gen
//  Purpose  : Raster timing generator for the TFT-LCD path. Produces the pixel
//             strobe, H/V counters, active-low Hsync/Vsync, data-enable and
//             line/frame start pulses. A run request stops only on a frame
//             boundary so that no partial frame is ever emitted.
//  Revision : 1.0 - initial release
// ============================================================================
module tft_timing_gen #(
   parameter int H_ACTIVE = 480,
   parameter int H_FP     = 2,
   parameter int H_SYNC   = 41,
   parameter int H_BP     = 2,
   parameter int V_ACTIVE = 272,
   parameter int V_FP     = 2,
   parameter int V_SYNC   = 10,
   parameter int V_BP     = 2,
   parameter int DIV      = 2
) (
   input  logic       CLK,
   input  logic       nRESET,
   input  logic       EN,
   output logic       PCLK_EN,
   output logic [9:0] H_COUNT,
   output logic [9:0] V_COUNT,
   output logic       Hsync,
   output logic       Vsync,
   output logic       hDE,
   output logic       vDE,
   output logic       DE,
   output logic       LINE_START,
   output logic       FRAME_START
);

   localparam int c_h_total = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int c_v_total = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int c_div_w   = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [c_div_w-1:0] c_div_last = c_div_w'(DIV - 1);
   localparam logic [9:0]  c_h_last      = 10'(c_h_total - 1);
   localparam logic [9:0]  c_v_last      = 10'(c_v_total - 1);
   // Window bounds are one bit wider so an edge at 1024 cannot alias to 0
   localparam logic [10:0] c_h_sync_end  = 11'(H_SYNC);
   localparam logic [10:0] c_h_act_beg   = 11'(H_SYNC + H_BP);
   localparam logic [10:0] c_h_act_end   = 11'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [10:0] c_v_sync_end  = 11'(V_SYNC);
   localparam logic [10:0] c_v_act_beg   = 11'(V_SYNC + V_BP);
   localparam logic [10:0] c_v_act_end   = 11'(V_SYNC + V_BP + V_ACTIVE);

   localparam logic [1:0] c_st_idle = 2'd0;
   localparam logic [1:0] c_st_run  = 2'd1;
   localparam logic [1:0] c_st_stop = 2'd2;

   // Reject geometries the 10-bit counters cannot represent
   generate
      if (c_h_total > 1024 || c_v_total > 1024) begin : g_bad_total
         $error("tft_timing_gen: H_TOTAL and V_TOTAL must both be <= 1024");
      end
      if (DIV < 1) begin : g_bad_div
         $error("tft_timing_gen: DIV must be >= 1");
      end
   endgenerate

   logic [1:0]         state_q, state_d;
   logic [c_div_w-1:0] div_q, div_d;
   logic [9:0]         h_q, h_d;
   logic [9:0]         v_q, v_d;
   logic               pclk_q, pclk_d;
   logic               hsync_q, hsync_d;
   logic               vsync_q, vsync_d;
   logic               hde_q, hde_d;
   logic               vde_q, vde_d;
   logic               de_q, de_d;
   logic               ls_q, ls_d;
   logic               fs_q, fs_d;
   logic               w_pix;
   logic               w_frame_end;
   logic               w_active;

   // Next-state: divider/raster advance and run/stop control
   always_comb begin
      state_d     = state_q;
      div_d       = div_q;
      h_d         = h_q;
      v_d         = v_q;
      w_pix       = (state_q != c_st_idle) && (div_q == c_div_last);
      w_frame_end = w_pix && (h_q == c_h_last) && (v_q == c_v_last);

      // Raster free-runs in RUN and STOP; IDLE and frame-end stop override it
      if (w_pix) begin
         div_d = '0;
         if (h_q == c_h_last) begin
            h_d = '0;
            v_d = (v_q == c_v_last) ? 10'd0 : v_q + 10'd1;
         end else begin
            h_d = h_q + 10'd1;
         end
      end else begin
         div_d = div_q + 1'b1;
      end

      case (state_q)
         c_st_idle: begin
            div_d = '0;
            h_d   = '0;
            v_d   = '0;
            if (EN) state_d = c_st_run;
         end
         c_st_run: begin
            if (!EN) state_d = c_st_stop;
         end
         c_st_stop: begin
            // A re-raised EN wins over the frame-end so the raster never breaks
            if (EN) begin
               state_d = c_st_run;
            end else if (w_frame_end) begin
               state_d = c_st_idle;
               div_d   = '0;
               h_d     = '0;
               v_d     = '0;
            end
         end
         default: begin
            state_d = c_st_idle;
            div_d   = '0;
            h_d     = '0;
            v_d     = '0;
         end
      endcase
   end

   // Output decode from next-state values so registered outputs match the counters
   always_comb begin
      w_active = (state_d != c_st_idle);
      pclk_d   = w_active && (div_d == c_div_last);
      hsync_d  = !(w_active && ({1'b0, h_d} < c_h_sync_end));
      vsync_d  = !(w_active && ({1'b0, v_d} < c_v_sync_end));
      hde_d    = w_active && ({1'b0, h_d} >= c_h_act_beg) && ({1'b0, h_d} < c_h_act_end);
      vde_d    = w_active && ({1'b0, v_d} >= c_v_act_beg) && ({1'b0, v_d} < c_v_act_end);
      de_d     = hde_d && vde_d;
      ls_d     = w_active && (div_d == '0) && (h_d == 10'd0);
      fs_d     = ls_d && (v_d == 10'd0);
   end

   // State, counters and all outputs registered; reset forces the IDLE picture
   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         state_q <= c_st_idle;
         div_q   <= '0;
         h_q     <= '0;
         v_q     <= '0;
         pclk_q  <= 1'b0;
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
         hde_q   <= 1'b0;
         vde_q   <= 1'b0;
         de_q    <= 1'b0;
         ls_q    <= 1'b0;
         fs_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         h_q     <= h_d;
         v_q     <= v_d;
         pclk_q  <= pclk_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         hde_q   <= hde_d;
         vde_q   <= vde_d;
         de_q    <= de_d;
         ls_q    <= ls_d;
         fs_q    <= fs_d;
      end
   end

   assign PCLK_EN     = pclk_q;
   assign H_COUNT     = h_q;
   assign V_COUNT     = v_q;
   assign Hsync       = hsync_q;
   assign Vsync       = vsync_q;
   assign hDE         = hde_q;
   assign vDE         = vde_q;
   assign DE          = de_q;
   assign LINE_START  = ls_q;
   assign FRAME_START = fs_q;

endmodule
`default_nettype wire

// File: tb/tb_tft_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tft_timing_gen
//  Purpose  : Directed self-checking bench for tft_timing_gen using a small
//             14x8 raster with DIV=2. Expected outputs come from a cycle-count
//             model of the raster (pixel = t/2, line = pixel/14, ...).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tft_timing_gen;

   logic       CLK = 1'b0;
   logic       nRESET;
   logic       EN;
   logic       PCLK_EN;
   logic [9:0] H_COUNT;
   logic [9:0] V_COUNT;
   logic       Hsync, Vsync, hDE, vDE, DE, LINE_START, FRAME_START;

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [27:0] c_idle_vec = {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 5'b00000};

   tft_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .DIV(2)
   ) dut (
      .CLK(CLK), .nRESET(nRESET), .EN(EN),
      .PCLK_EN(PCLK_EN), .H_COUNT(H_COUNT), .V_COUNT(V_COUNT),
      .Hsync(Hsync), .Vsync(Vsync), .hDE(hDE), .vDE(vDE), .DE(DE),
      .LINE_START(LINE_START), .FRAME_START(FRAME_START)
   );

   always #5 CLK = ~CLK;

   function automatic logic [27:0] obs_vec();
      return {PCLK_EN, H_COUNT, V_COUNT, Hsync, Vsync, hDE, vDE, DE, LINE_START, FRAME_START};
   endfunction

   // Expected outputs t cycles after the cycle in which the raster (re)started at (0,0)
   function automatic logic [27:0] exp_vec(input int t);
      int p, h, v;
      logic hde, vde;
      p   = t / 2;
      h   = p % 14;
      v   = (p / 14) % 8;
      hde = (h >= 4) && (h < 12);
      vde = (v >= 3) && (v < 7);
      return {(t % 2) == 1, 10'(h), 10'(v), !(h < 3), !(v < 2), hde, vde, hde && vde,
              (t % 28) == 0, (t % 224) == 0};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", tag, $time, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Raise EN, then check n_cyc raster cycles; EN is dropped/raised after the given t
   task automatic run_raster(input int n_cyc, input int drop_t, input int raise_t,
                             output int de_cnt, output int ls_cnt, output int fs_gap);
      int fs_first;
      de_cnt   = 0;
      ls_cnt   = 0;
      fs_gap   = -1;
      fs_first = -1;
      EN = 1'b1;
      for (int t = 0; t < n_cyc; t++) begin
         tick();
         chk($sformatf("raster t=%0d", t), 32'(obs_vec()), 32'(exp_vec(t)));
         if (t < 224 && DE) de_cnt++;
         if (t < 224 && LINE_START) ls_cnt++;
         if (FRAME_START) begin
            if (fs_first < 0) fs_first = t;
            else if (fs_gap < 0) fs_gap = t - fs_first;
         end
         if (t == drop_t)  EN = 1'b0;
         if (t == raise_t) EN = 1'b1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int de_cnt, ls_cnt, fs_gap;
      nRESET = 1'b0;
      EN     = 1'b0;
      #3;
      @(posedge CLK);
      #1;
      chk("reset", 32'(obs_vec()), 32'(c_idle_vec));

      // Idle with EN low after reset release
      @(negedge CLK);
      nRESET = 1'b1;
      for (int i = 0; i < 50; i++) begin
         tick();
         chk("idle", 32'(obs_vec()), 32'(c_idle_vec));
      end

      // Start, two frames, stop requested at (5,4) of the second frame
      run_raster(448, 346, -1, de_cnt, ls_cnt, fs_gap);
      chk("de_cycles_frame", 32'(de_cnt), 32'd64);
      chk("line_starts_frame", 32'(ls_cnt), 32'd8);
      chk("frame_start_gap", 32'(fs_gap), 32'd224);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stopped_idle", 32'(obs_vec()), 32'(c_idle_vec));
      end

      // Drop EN, re-raise well before the frame end: raster must be continuous
      run_raster(383, 122, 200, de_cnt, ls_cnt, fs_gap);
      chk("resume_frame_start_gap", 32'(fs_gap), 32'd224);
      chk("pos_before_async", 32'({H_COUNT, V_COUNT}), 32'({10'd9, 10'd5}));

      // Asynchronous reset between clock edges at (9,5)
      #2;
      nRESET = 1'b0;
      #1;
      chk("async_reset", 32'(obs_vec()), 32'(c_idle_vec));
      EN = 1'b0;
      @(negedge CLK);
      nRESET = 1'b1;
      tick();
      chk("post_reset_idle", 32'(obs_vec()), 32'(c_idle_vec));

      // EN re-raised exactly for the frame-end edge: wrap to (0,0) with FRAME_START
      run_raster(240, 100, 223, de_cnt, ls_cnt, fs_gap);
      chk("edge_resume_frame_start_gap", 32'(fs_gap), 32'd224);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
